// File: rtl/bpred_pkg.sv
// Shared branch-prediction types and constants for the GHR checkpoint logic.
package bpred_pkg;

  localparam int BPRED_WIDTH = 9;

  typedef struct packed {
    logic [BPRED_WIDTH-1:0] history;
    logic                   prediction;
  } ghr_ckpt_t;

  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;

endpackage

// File: rtl/ghr_ckpt_fifo.sv
// In-order checkpoint store: circular buffer with occupancy count and a flush
// that retires the head entry and discards everything younger.
module ghr_ckpt_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Push,
  input  logic [WIDTH-1:0] i_Push_Data,
  input  logic             i_Pop,
  input  logic             i_Flush,
  output logic [WIDTH-1:0] o_Rd_Data,
  output logic [PTR_W:0]   o_Count,
  output logic             o_Full,
  output logic             o_Empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // A flush means the head resolved wrong, so any same-cycle push is wrong-path.
  assign w_push  = i_Push && !w_full && !i_Flush;
  assign w_pop   = i_Pop && !w_empty;

  always_ff @(posedge i_Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_Push_Data;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_Flush) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
      r_wr_ptr <= r_rd_ptr + 1'b1;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_Rd_Data = r_mem[r_rd_ptr];
  assign o_Count   = r_count;
  assign o_Full    = w_full;
  assign o_Empty   = w_empty;

endmodule

// File: rtl/ghr_checkpoint_ctrl.sv
// GHR checkpoint/repair controller. Optional resolve/mispredict statistics are
// built when GHR_CKPT_STATS_EN is defined.
module ghr_checkpoint_ctrl #(
  parameter  int BPRED_WIDTH = bpred_pkg::BPRED_WIDTH,
  parameter  int DEPTH       = 4,
  localparam int PTR_W       = $clog2(DEPTH)
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_DEC_Is_Branch,
  input  logic                   i_Prediction,
  input  logic [BPRED_WIDTH-1:0] i_Global_History,
  input  logic                   i_ALU_Branch_Valid,
  input  logic                   i_ALU_Branch_Outcome,
  output logic                   o_Stall,
  output logic                   o_Restore_Valid,
  output logic [BPRED_WIDTH-1:0] o_Restore_History,
  output logic [PTR_W:0]         o_Count,
  output logic                   o_Empty
`ifdef GHR_CKPT_STATS_EN
  ,
  output logic [31:0]            o_Resolved_Count,
  output logic [31:0]            o_Mispredict_Count
`endif
);

  logic [BPRED_WIDTH:0]   w_rd_data;
  logic [BPRED_WIDTH-1:0] w_rd_history;
  logic                   w_rd_prediction;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push_acc;
  logic                   w_pop;
  logic                   w_mispredict;

  logic                   r_restore_valid;
  logic [BPRED_WIDTH-1:0] r_restore_history;

  // Stall depends on registered occupancy only; a same-cycle pop cannot free a slot.
  assign w_push_acc = i_DEC_Is_Branch && !w_full;
  assign w_pop      = i_ALU_Branch_Valid && !w_empty;

  ghr_ckpt_fifo #(
    .WIDTH (BPRED_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Push      (w_push_acc),
    .i_Push_Data ({i_Global_History, i_Prediction}),
    .i_Pop       (w_pop),
    .i_Flush     (w_mispredict),
    .o_Rd_Data   (w_rd_data),
    .o_Count     (o_Count),
    .o_Full      (w_full),
    .o_Empty     (w_empty)
  );

  assign w_rd_history    = w_rd_data[BPRED_WIDTH:1];
  assign w_rd_prediction = w_rd_data[0];
  assign w_mispredict    = w_pop && (i_ALU_Branch_Outcome != w_rd_prediction);

  // Corrected history = pre-insertion snapshot with the real outcome shifted in.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_restore_valid   <= 1'b0;
      r_restore_history <= '0;
    end else begin
      r_restore_valid <= w_mispredict;
      if (w_mispredict) begin
        r_restore_history <= {w_rd_history[BPRED_WIDTH-2:0], i_ALU_Branch_Outcome};
      end
    end
  end

  assign o_Stall           = w_full;
  assign o_Empty           = w_empty;
  assign o_Restore_Valid   = r_restore_valid;
  assign o_Restore_History = r_restore_history;

`ifdef GHR_CKPT_STATS_EN
  logic [31:0] r_resolved_count;
  logic [31:0] r_mispredict_count;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_resolved_count   <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_pop && (r_resolved_count != 32'hFFFF_FFFF)) begin
        r_resolved_count <= r_resolved_count + 1'b1;
      end
      if (w_mispredict && (r_mispredict_count != 32'hFFFF_FFFF)) begin
        r_mispredict_count <= r_mispredict_count + 1'b1;
      end
    end
  end

  assign o_Resolved_Count   = r_resolved_count;
  assign o_Mispredict_Count = r_mispredict_count;
`endif

endmodule
